// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, ALU op codes, mux selects and
// the multicycle control FSM state encodings.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC    = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ADDI_WB = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state decode for the multicycle main control FSM.
// Jump decode is present only when MC_JUMP_EN is defined.
module mc_next_state
    import mips_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  state_t          state,
    input  logic [OP_W-1:0] opcode,
    output state_t          next_state
);

    // NOTE: next_state gets a default before the case so that no path can infer a latch.
    always_comb begin
        next_state = S_FETCH;
        unique case (state)
            S_FETCH:   next_state = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) next_state = S_MEM_ADR;
                else if (opcode == OP_RTYPE)            next_state = S_EXEC;
                else if (opcode == OP_BEQ)              next_state = S_BRANCH;
                else if (opcode == OP_ADDI)             next_state = S_ADDI_EX;
`ifdef MC_JUMP_EN
                else if (opcode == OP_J)                next_state = S_JUMP;
`endif
                else                                    next_state = S_FETCH;
            end
            S_MEM_ADR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  next_state = S_MEM_WB;
            S_EXEC:    next_state = S_ALU_WB;
            S_ADDI_EX: next_state = S_ADDI_WB;
            default:   next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM (Moore): sequences fetch/decode/execute/
// memory/writeback and drives datapath enables. Optional jump: MC_JUMP_EN.
module mc_main_control
    import mips_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               addi,
    output logic [1:0]         pc_source,
    output logic [STATE_W-1:0] state
);

    state_t cur_state;
    state_t nxt_state;
    logic   pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s, ir_write_s, reg_write_s;

    mc_next_state #(.OP_W(OP_W)) u_next_state (
        .state      (cur_state),
        .opcode     (opcode),
        .next_state (nxt_state)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) cur_state <= S_FETCH;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        i_or_d          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg      = 1'b0;
        reg_dst         = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = SRCB_REG;
        alu_op          = ALUOP_ADD;
        addi            = 1'b0;
        pc_source       = PCSRC_ALU;
        unique case (cur_state)
            S_FETCH: begin
                mem_read_s = 1'b1;
                ir_write_s = 1'b1;
                alu_src_b  = SRCB_FOUR;
                pc_write_s = 1'b1;
            end
            S_DECODE:  alu_src_b = SRCB_IMMSH;
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read_s = 1'b1;
                i_or_d     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_s = 1'b1;
                i_or_d      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNC;
            end
            S_ALU_WB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = ALUOP_SUB;
                pc_write_cond_s = 1'b1;
                pc_source       = PCSRC_ALUOUT;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNC;
                addi      = 1'b1;
            end
            S_ADDI_WB: reg_write_s = 1'b1;
`ifdef MC_JUMP_EN
            S_JUMP: begin
                pc_write_s = 1'b1;
                pc_source  = PCSRC_JUMP;
            end
`endif
            default: ;
        endcase
    end

    // Reset suppresses every side-effecting strobe, even mid-instruction.
    assign pc_write      = pc_write_s      & ~reset;
    assign pc_write_cond = pc_write_cond_s & ~reset;
    assign mem_read      = mem_read_s      & ~reset;
    assign mem_write     = mem_write_s     & ~reset;
    assign ir_write      = ir_write_s      & ~reset;
    assign reg_write     = reg_write_s     & ~reset;

    assign state = STATE_W'(cur_state);

endmodule

// File: tb/tb_mc_main_control.sv
// Directed self-checking bench for mc_main_control; expects the jump path
// only when MC_JUMP_EN is defined for the build.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b000000;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, addi;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    mc_main_control #(.OP_W(6), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .addi(addi), .pc_source(pc_source), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] strobes;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            tick();
            strobes = {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write};
            checks++;
            if (state !== 4'd0) begin
                errors++; $display("FAIL reset_state cyc%0d: got %0d want 0", i, state);
            end
            checks++;
            if (strobes !== 6'b0) begin
                errors++; $display("FAIL reset_strobes cyc%0d: got %b want 000000", i, strobes);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_read, ir_write, pc_write, alu_src_b, i_or_d, alu_src_a, alu_op, pc_source}
            !== {1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL fetch_outputs: got rd=%b irw=%b pcw=%b srcb=%b iord=%b srca=%b aluop=%b pcsrc=%b",
                     mem_read, ir_write, pc_write, alu_src_b, i_or_d, alu_src_a, alu_op, pc_source);
        end
    endtask

    task automatic test_lw();
        int exp_s[6] = '{0, 1, 2, 3, 4, 0};
        opcode = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (state !== exp_s[i][3:0]) begin
                errors++; $display("FAIL lw_state step%0d: got %0d want %0d", i, state, exp_s[i]);
            end
            if (i == 3) begin
                checks++;
                if ({i_or_d, mem_read, reg_write} !== 3'b110) begin
                    errors++; $display("FAIL lw_mem_rd: got iord/rd/rw=%b want 110", {i_or_d, mem_read, reg_write});
                end
                opcode = 6'b000000;  // must be ignored outside DECODE/MEM_ADR
            end
            if (i == 4) begin
                checks++;
                if ({reg_write, mem_to_reg, reg_dst} !== 3'b110) begin
                    errors++; $display("FAIL lw_mem_wb: got rw/m2r/dst=%b want 110", {reg_write, mem_to_reg, reg_dst});
                end
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_sw();
        int exp_s[5] = '{0, 1, 2, 5, 0};
        opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== exp_s[i][3:0]) begin
                errors++; $display("FAIL sw_state step%0d: got %0d want %0d", i, state, exp_s[i]);
            end
            if (i == 3) begin
                checks++;
                if ({mem_write, i_or_d, mem_read, reg_write} !== 4'b1100) begin
                    errors++; $display("FAIL sw_mem_wr: got wr/iord/rd/rw=%b want 1100", {mem_write, i_or_d, mem_read, reg_write});
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_rtype_addi();
        int exp_r[5] = '{0, 1, 6, 7, 0};
        int exp_a[5] = '{0, 1, 9, 10, 0};
        opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== exp_r[i][3:0]) begin
                errors++; $display("FAIL rtype_state step%0d: got %0d want %0d", i, state, exp_r[i]);
            end
            if (i == 2) begin
                checks++;
                if ({alu_op, addi, alu_src_a, alu_src_b} !== 6'b100100) begin
                    errors++; $display("FAIL rtype_exec: got aluop/addi/srca/srcb=%b want 100100", {alu_op, addi, alu_src_a, alu_src_b});
                end
            end
            if (i == 3) begin
                checks++;
                if ({reg_dst, reg_write, mem_to_reg} !== 3'b110) begin
                    errors++; $display("FAIL rtype_wb: got dst/rw/m2r=%b want 110", {reg_dst, reg_write, mem_to_reg});
                end
            end
            if (i < 4) tick();
        end
        opcode = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== exp_a[i][3:0]) begin
                errors++; $display("FAIL addi_state step%0d: got %0d want %0d", i, state, exp_a[i]);
            end
            if (i == 2) begin
                checks++;
                if ({addi, alu_src_b, alu_op, alu_src_a} !== 6'b110101) begin
                    errors++; $display("FAIL addi_ex: got addi/srcb/aluop/srca=%b want 110101", {addi, alu_src_b, alu_op, alu_src_a});
                end
            end
            if (i == 3) begin
                checks++;
                if ({reg_write, reg_dst, mem_to_reg, addi} !== 4'b1000) begin
                    errors++; $display("FAIL addi_wb: got rw/dst/m2r/addi=%b want 1000", {reg_write, reg_dst, mem_to_reg, addi});
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_beq();
        int exp_s[4] = '{0, 1, 8, 0};
        opcode = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== exp_s[i][3:0]) begin
                errors++; $display("FAIL beq_state step%0d: got %0d want %0d", i, state, exp_s[i]);
            end
            if (i == 2) begin
                checks++;
                if ({alu_op, pc_write_cond, pc_source, pc_write} !== 6'b011010) begin
                    errors++; $display("FAIL beq_branch: got aluop/pwc/pcsrc/pcw=%b want 011010", {alu_op, pc_write_cond, pc_source, pc_write});
                end
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_illegal_jump();
`ifdef MC_JUMP_EN
        int exp_j[4] = '{0, 1, 11, 0};
        int n_j = 4;
`else
        int exp_j[4] = '{0, 1, 0, 1};
        int n_j = 3;
`endif
        int exp_i[3] = '{0, 1, 0};
        opcode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== exp_i[i][3:0] || reg_write !== 1'b0 || mem_write !== 1'b0) begin
                errors++; $display("FAIL illegal step%0d: got state=%0d rw=%b wr=%b want %0d,0,0", i, state, reg_write, mem_write, exp_i[i]);
            end
            if (i < 2) tick();
        end
        opcode = 6'b000010;
        for (int i = 0; i < n_j; i++) begin
            checks++;
            if (state !== exp_j[i][3:0]) begin
                errors++; $display("FAIL jump_state step%0d: got %0d want %0d", i, state, exp_j[i]);
            end
`ifdef MC_JUMP_EN
            if (i == 2) begin
                checks++;
                if ({pc_write, pc_source} !== 3'b110) begin
                    errors++; $display("FAIL jump_out: got pcw/pcsrc=%b want 110", {pc_write, pc_source});
                end
            end
`endif
            if (i < n_j - 1) tick();
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011;
        tick(); tick(); tick();
        checks++;
        if (state !== 4'd3) begin
            errors++; $display("FAIL mid_pre_state: got %0d want 3", state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_read, reg_write, i_or_d} !== 3'b001) begin
            errors++; $display("FAIL mid_strobes: got rd/rw/iord=%b want 001", {mem_read, reg_write, i_or_d});
        end
        tick();
        checks++;
        if (state !== 4'd0 || reg_write !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got state=%0d rw=%b want 0,0", state, reg_write);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (state !== 4'd1 || reg_write !== 1'b0) begin
            errors++; $display("FAIL mid_resume: got state=%0d rw=%b want 1,0", state, reg_write);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype_addi();
        test_beq();
        test_illegal_jump();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
